// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder.
package spi_cmd_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StWrData,
      StRdFetch,
      StRdWait,
      StRdSend,
      StDone
   } state_e;

   localparam int unsigned CMD_RD_BIT = 7;
   localparam logic [7:0]  FILL_BYTE  = 8'hFF;
   localparam int unsigned RD_LAT_MAX = 3;

endpackage

// File: rtl/spi_cmd_sync.sv
// Two-flop synchroniser for the raw chip select, with one-cycle edge pulses.
// Resets to 1 so a held-low select after reset still produces a frame start.
module spi_cmd_sync (
   input  logic clk,
   input  logic reset,
   input  logic ssel_n,
   output logic ssel_rise,
   output logic ssel_fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronise and keep the previous synchronised value for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= ssel_n;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign ssel_rise = sync_q & ~prev_q;
   assign ssel_fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns the byte stream of one SSEL frame into register-bus reads/writes.
// Frame: cmd byte {rw, addr} then data bytes; read data is returned via byte_send.
// Optional feature: define SPI_CMD_AUTOINC_EN for unlimited address-incrementing bursts;
// without it a frame carries one data byte and further reads return the fill byte.
module spi_cmd_decoder
   import spi_cmd_pkg::*;
#(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ssel_n,
   input  logic              byte_received,
   input  logic [7:0]        byte_received_data,
   output logic              byte_send,
   output logic [7:0]        byte_send_data,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              reg_wr,
   output logic [7:0]        reg_wdata,
   output logic              reg_rd,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic              overrun
);

   // Wait counter compares against this; capture lands RD_LAT+1 cycles after reg_rd.
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        lat_q;
   logic              frame_start;
   logic              frame_end;

   spi_cmd_sync u_sync (
      .clk       (clk),
      .reset     (reset),
      .ssel_n    (ssel_n),
      .ssel_rise (frame_end),
      .ssel_fall (frame_start)
   );

   assign busy = (state_q != StIdle);

   // Frame FSM with registered bus strobes and send-side outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         addr_q         <= '0;
         lat_q          <= '0;
         reg_addr       <= '0;
         reg_wr         <= 1'b0;
         reg_wdata      <= 8'h00;
         reg_rd         <= 1'b0;
         byte_send      <= 1'b0;
         byte_send_data <= 8'h00;
         overrun        <= 1'b0;
      end else begin
         reg_wr <= 1'b0;
         reg_rd <= 1'b0;
         // Frame end beats everything, including a byte arriving in the same cycle
         if (frame_end) begin
            state_q   <= StIdle;
            byte_send <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (frame_start) begin
                     state_q <= StCmd;
                     overrun <= 1'b0;
                  end
               end
               StCmd: begin
                  if (byte_received) begin
                     addr_q  <= byte_received_data[ADDR_W-1:0];
                     state_q <= byte_received_data[CMD_RD_BIT] ? StRdFetch : StWrData;
                  end
               end
               StWrData: begin
                  if (byte_received) begin
                     reg_wr    <= 1'b1;
                     reg_addr  <= addr_q;
                     reg_wdata <= byte_received_data;
`ifdef SPI_CMD_AUTOINC_EN
                     addr_q    <= addr_q + 1'b1;
`else
                     state_q        <= StDone;
                     byte_send      <= 1'b1;
                     byte_send_data <= FILL_BYTE;
`endif
                  end
               end
               StRdFetch: begin
                  if (byte_received) overrun <= 1'b1;
                  reg_rd   <= 1'b1;
                  reg_addr <= addr_q;
                  lat_q    <= '0;
                  state_q  <= StRdWait;
               end
               StRdWait: begin
                  // Bytes arriving before the read data is ready are dropped
                  if (byte_received) overrun <= 1'b1;
                  if (lat_q == LAT_LAST) begin
                     byte_send_data <= reg_rdata;
                     byte_send      <= 1'b1;
                     state_q        <= StRdSend;
                  end else begin
                     lat_q <= lat_q + 2'd1;
                  end
               end
               StRdSend: begin
                  if (byte_received) begin
`ifdef SPI_CMD_AUTOINC_EN
                     byte_send <= 1'b0;
                     addr_q    <= addr_q + 1'b1;
                     state_q   <= StRdFetch;
`else
                     // Straight into the fill byte for any further clocks
                     byte_send      <= 1'b1;
                     byte_send_data <= FILL_BYTE;
                     state_q        <= StDone;
`endif
                  end
               end
               StDone: begin
                  byte_send      <= 1'b1;
                  byte_send_data <= FILL_BYTE;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed scenarios plus random frames
// compared against a frame-level reference model.
module tb_spi_cmd_decoder;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned RD_LAT = 1;
   localparam int unsigned GAP    = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ssel_n = 1'b1;
   logic              byte_received = 1'b0;
   logic [7:0]        byte_received_data = 8'h00;
   logic              byte_send;
   logic [7:0]        byte_send_data;
   logic [ADDR_W-1:0] reg_addr;
   logic              reg_wr;
   logic [7:0]        reg_wdata;
   logic              reg_rd;
   logic [7:0]        reg_rdata;
   logic              busy;
   logic              overrun;

   always #5 clk = ~clk;

   spi_cmd_decoder #(
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .ssel_n             (ssel_n),
      .byte_received      (byte_received),
      .byte_received_data (byte_received_data),
      .byte_send          (byte_send),
      .byte_send_data     (byte_send_data),
      .reg_addr           (reg_addr),
      .reg_wr             (reg_wr),
      .reg_wdata          (reg_wdata),
      .reg_rd             (reg_rd),
      .reg_rdata          (reg_rdata),
      .busy               (busy),
      .overrun            (overrun)
   );

   // Register file stand-in: read data valid exactly RD_LAT cycles after reg_rd
   logic [7:0] mem [128];
   logic       rd_v [RD_LAT];
   logic [6:0] rd_a [RD_LAT];

   always @(posedge clk) begin
      rd_v[0] <= reg_rd;
      rd_a[0] <= reg_addr;
      for (int i = 1; i < RD_LAT; i++) begin
         rd_v[i] <= rd_v[i-1];
         rd_a[i] <= rd_a[i-1];
      end
   end

   assign reg_rdata = (rd_v[RD_LAT-1] === 1'b1) ? mem[rd_a[RD_LAT-1]] : 8'hEE;

   // Bus monitor, sampled mid-cycle
   logic [14:0] wr_log [$];
   logic [6:0]  rd_log [$];
   logic [8:0]  tx_log [$];
   bit          send_seen;

   always @(negedge clk) begin
      if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_rd) rd_log.push_back(reg_addr);
      if (byte_received) tx_log.push_back(byte_send ? {1'b1, byte_send_data} : 9'h000);
      if (byte_send) send_seen = 1'b1;
   end

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      tick(1);
      byte_received      = 1'b1;
      byte_received_data = b;
      tick(1);
      byte_received      = 1'b0;
      tick(gap);
   endtask

   task automatic start_frame(input string tag);
      wr_log.delete();
      rd_log.delete();
      tx_log.delete();
      send_seen = 1'b0;
      ssel_n = 1'b0;
      tick(5);
      check({tag, " busy at start"}, busy, 1);
   endtask

   task automatic end_frame(input string tag);
      ssel_n = 1'b1;
      tick(6);
      check({tag, " busy after end"}, busy, 0);
      check({tag, " byte_send after end"}, byte_send, 0);
   endtask

   // Reference model: expected bus traffic and MISO bytes for the whole frame
   logic [7:0]  frame_q [$];
   logic [14:0] exp_wr [$];
   logic [6:0]  exp_rd [$];
   logic [8:0]  exp_tx [$];

   task automatic build_expected();
      logic [6:0] a;
      int         n;
      exp_wr.delete();
      exp_rd.delete();
      exp_tx.delete();
      n = frame_q.size();
      a = frame_q[0][6:0];
      exp_tx.push_back(9'h000);
      if (frame_q[0][7]) begin
`ifdef SPI_CMD_AUTOINC_EN
         for (int i = 0; i < n; i++) exp_rd.push_back(7'(a + i));
         for (int i = 1; i < n; i++) exp_tx.push_back({1'b1, mem[7'(a + i - 1)]});
`else
         exp_rd.push_back(a);
         for (int i = 1; i < n; i++) exp_tx.push_back(i == 1 ? {1'b1, mem[a]} : 9'h1FF);
`endif
      end else begin
`ifdef SPI_CMD_AUTOINC_EN
         for (int i = 1; i < n; i++) begin
            exp_wr.push_back({7'(a + i - 1), frame_q[i]});
            exp_tx.push_back(9'h000);
         end
`else
         if (n > 1) exp_wr.push_back({a, frame_q[1]});
         for (int i = 1; i < n; i++) exp_tx.push_back(i == 1 ? 9'h000 : 9'h1FF);
`endif
      end
   endtask

   task automatic run_and_check(input string tag);
      start_frame(tag);
      foreach (frame_q[i]) send_byte(frame_q[i], GAP);
      end_frame(tag);
      build_expected();
      check({tag, " wr count"}, wr_log.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size(); i++)
         if (i < wr_log.size()) check($sformatf("%s wr%0d", tag, i), wr_log[i], exp_wr[i]);
      check({tag, " rd count"}, rd_log.size(), exp_rd.size());
      for (int i = 0; i < exp_rd.size(); i++)
         if (i < rd_log.size()) check($sformatf("%s rd%0d", tag, i), rd_log[i], exp_rd[i]);
      check({tag, " tx count"}, tx_log.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size(); i++)
         if (i < tx_log.size()) check($sformatf("%s tx%0d", tag, i), tx_log[i], exp_tx[i]);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " byte_send"}, byte_send, 0);
      check({tag, " byte_send_data"}, byte_send_data, 0);
      check({tag, " reg_addr"}, reg_addr, 0);
      check({tag, " reg_wr"}, reg_wr, 0);
      check({tag, " reg_wdata"}, reg_wdata, 0);
      check({tag, " reg_rd"}, reg_rd, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " overrun"}, overrun, 0);
   endtask

   initial begin
      int cnt;
      bit found;

      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      mem[3] = 8'h3C;

      // Reset state
      tick(3);
      check_all_zero("reset");
      reset = 1'b0;
      tick(3);

      // Single write
      frame_q = '{8'h05, 8'hA5};
      run_and_check("wr1");
      check("wr1 one write", wr_log.size(), 1);
      if (wr_log.size() > 0) check("wr1 addr/data", wr_log[0], {7'h05, 8'hA5});
      check("wr1 no read", rd_log.size(), 0);

      // Read with latency measurement
      start_frame("rd2");
      send_byte(8'h83, 0);
      cnt = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         cnt++;
         if (reg_rd) found = 1'b1;
      end
      check("rd2 cmd->reg_rd cycles", cnt, 2);
      check("rd2 reg_rd addr", reg_addr, 7'h03);
      cnt = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         cnt++;
         if (byte_send) found = 1'b1;
      end
      check("rd2 reg_rd->byte_send cycles", cnt, RD_LAT + 1);
      tick(6);
      check("rd2 byte_send held", byte_send, 1);
      check("rd2 byte_send_data", byte_send_data, 8'h3C);
      send_byte(8'h00, GAP);
      check("rd2 read count", rd_log.size(), 1);
      if (tx_log.size() > 1) check("rd2 shifted byte", tx_log[1], {1'b1, 8'h3C});
      end_frame("rd2");

      // Write burst across the address wrap
      frame_q = '{8'h7F, 8'h11, 8'h22};
      run_and_check("wr3");
`ifdef SPI_CMD_AUTOINC_EN
      check("wr3 write count", wr_log.size(), 2);
      if (wr_log.size() > 1) check("wr3 wrapped write", wr_log[1], {7'h00, 8'h22});
`else
      check("wr3 write count", wr_log.size(), 1);
`endif
      if (wr_log.size() > 0) check("wr3 first write", wr_log[0], {7'h7F, 8'h11});

      // Overrun: byte lands while read data is still pending
      start_frame("ovr4");
      send_byte(8'h81, 0);
      send_byte(8'h00, GAP);
      check("ovr4 overrun set", overrun, 1);
      check("ovr4 byte_send after fetch", byte_send, 1);
      check("ovr4 data after fetch", byte_send_data, mem[1]);
      end_frame("ovr4");
      check("ovr4 overrun sticky", overrun, 1);
      start_frame("ovr4b");
      check("ovr4 overrun cleared", overrun, 0);
      end_frame("ovr4b");

      // Abort right after a read command
      start_frame("abort5");
      send_byte(8'h84, 0);
      ssel_n = 1'b1;
      tick(8);
      check("abort5 busy", busy, 0);
      check("abort5 byte_send", byte_send, 0);
      check("abort5 byte_send never raised", send_seen, 0);
      check("abort5 no write", wr_log.size(), 0);

      // Random frames against the reference model
      for (int f = 0; f < 15; f++) begin
         int n;
         n = $urandom_range(1, 4);
         frame_q.delete();
         for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
         run_and_check($sformatf("rand%0d", f));
      end

      // Asynchronous reset mid-frame, then a normal frame
      start_frame("rst6");
      send_byte(8'h10, GAP);
      send_byte(8'h55, 3);
      #1;
      reset = 1'b1;
      #1;
      check_all_zero("rst6 async");
      ssel_n = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
      frame_q = '{8'h92};
      frame_q.push_back(8'h00);
      run_and_check("rst6 read");
      frame_q = '{8'h22, 8'h5A};
      run_and_check("rst6 write");

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
